// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: FSM state codes and the
// layout of one stored trace entry.
package wb_trace_buffer_pkg;

    localparam int PC_W    = 32;
    localparam int RD_W    = 5;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = PC_W + RD_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } traceState_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } traceEntry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one synchronous write port, one asynchronous read port
// so the FIFO head falls through to the outputs without a read cycle.
module trace_fifo_mem
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     Clk,
    input  logic                     WrEn,
    input  logic [$clog2(DEPTH)-1:0] WrAddr,
    input  logic [WIDTH-1:0]         WrData,
    input  logic [$clog2(DEPTH)-1:0] RdAddr,
    output logic [WIDTH-1:0]         RdData
);

    logic [WIDTH-1:0] storage [DEPTH];

    always_ff @(posedge Clk) begin
        if (WrEn) begin
            storage[WrAddr] <= WrData;
        end
    end

    assign RdData = storage[RdAddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace capture: PC-triggered recording of register-file writes
// into a first-word-fall-through FIFO drained over a valid/ready port.
//
// state   | meaning
// IDLE    | after reset, waiting for Arm
// ARMED   | waiting for the trigger event (or Stop)
// CAPTURE | every qualified write-back event is pushed
// DONE    | capture ended; FIFO still drains; Arm starts a new session
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Arm,
    input  logic                   Stop,
    input  logic                   TrigAny,
    input  logic [31:0]            TriggerPC,
    input  logic                   WbValid,
    input  logic [31:0]            WbPC,
    input  logic [4:0]             WbRd,
    input  logic [31:0]            WbData,
    input  logic                   OutReady,
    output logic                   OutValid,
    output logic [31:0]            OutPC,
    output logic [4:0]             OutRd,
    output logic [31:0]            OutData,
    output logic [$clog2(DEPTH):0] Count,
    output logic [15:0]            Dropped,
    output logic [1:0]             State
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    traceState_t state, stateNext;
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic [15:0]   dropped;
    logic          qualified, triggerHit, push, flush, pop, full;
    logic          wrEn, lostEvent, rdAdvance;
    traceEntry_t   wrEntry, rdEntry;

    assign qualified  = WbValid && (WbRd != '0);
    assign triggerHit = qualified && (TrigAny || (WbPC == TriggerPC));
    assign full       = (count == FULL_COUNT);
    assign pop        = (count != '0) && OutReady;
    // When full, a push lands only if a pop frees the slot or overwrite is enabled.
    assign wrEn       = push && (!full || pop || (WRAP != 0));
    assign lostEvent  = push && full && !pop;
    assign rdAdvance  = pop || (wrEn && full);

    always_comb begin
        stateNext = state;
        push      = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (Arm) begin
                    stateNext = ARMED;
                    flush     = 1'b1;
                end
            end
            ARMED: begin
                if (Stop) begin
                    stateNext = DONE;
                end else if (triggerHit) begin
                    stateNext = CAPTURE;
                    push      = 1'b1;
                end
            end
            CAPTURE: begin
                if (Stop) begin
                    stateNext = DONE;
                end else begin
                    push = qualified;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            dropped <= '0;
        end else begin
            state <= stateNext;
            if (flush) begin
                wrPtr   <= '0;
                rdPtr   <= '0;
                count   <= '0;
                dropped <= '0;
            end else begin
                if (wrEn) wrPtr <= wrPtr + 1'b1;
                if (rdAdvance) rdPtr <= rdPtr + 1'b1;
                if (wrEn && !pop && !full) begin
                    count <= count + 1'b1;
                end else if (pop && !wrEn) begin
                    count <= count - 1'b1;
                end
                if (lostEvent && (dropped != 16'hFFFF)) begin
                    dropped <= dropped + 1'b1;
                end
            end
        end
    end

    assign wrEntry = '{pc: WbPC, rd: WbRd, data: WbData};

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) uMem (
        .Clk    (Clk),
        .WrEn   (wrEn),
        .WrAddr (wrPtr),
        .WrData (wrEntry),
        .RdAddr (rdPtr),
        .RdData (rdEntry)
    );

    assign OutValid = (count != '0);
    assign OutPC    = OutValid ? rdEntry.pc   : '0;
    assign OutRd    = OutValid ? rdEntry.rd   : '0;
    assign OutData  = OutValid ? rdEntry.data : '0;
    assign Count    = count;
    assign Dropped  = dropped;
    assign State    = state;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: a drop instance (WRAP=0) and an overwrite
// instance (WRAP=1) share stimulus; a queue model predicts every popped entry.
module tb_wb_trace_buffer;
    import wb_trace_buffer_pkg::*;

    localparam int DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Reset, Arm, Stop, TrigAny, WbValid, OutReady;
    logic [31:0] TriggerPC, WbPC, WbData;
    logic [4:0]  WbRd;

    logic        outValid0, outValid1;
    logic [31:0] outPC0, outPC1, outData0, outData1;
    logic [4:0]  outRd0, outRd1;
    logic [4:0]  count0, count1;
    logic [15:0] dropped0, dropped1;
    logic [1:0]  state0, state1;

    int checks = 0;
    int errors = 0;
    int pops0  = 0;
    int pops1  = 0;

    logic [68:0] q0[$];
    logic [68:0] q1[$];
    traceState_t mstate = IDLE;

    always #5 Clk = ~Clk;

    wb_trace_buffer #(.DEPTH(DEPTH), .WRAP(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Arm(Arm), .Stop(Stop), .TrigAny(TrigAny),
        .TriggerPC(TriggerPC), .WbValid(WbValid), .WbPC(WbPC), .WbRd(WbRd),
        .WbData(WbData), .OutReady(OutReady), .OutValid(outValid0), .OutPC(outPC0),
        .OutRd(outRd0), .OutData(outData0), .Count(count0), .Dropped(dropped0),
        .State(state0)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .WRAP(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Arm(Arm), .Stop(Stop), .TrigAny(TrigAny),
        .TriggerPC(TriggerPC), .WbValid(WbValid), .WbPC(WbPC), .WbRd(WbRd),
        .WbData(WbData), .OutReady(OutReady), .OutValid(outValid1), .OutPC(outPC1),
        .OutRd(outRd1), .OutData(outData1), .Count(count1), .Dropped(dropped1),
        .State(state1)
    );

    // One clock: compare any pop against the scoreboard, advance the model, clock.
    task automatic tick();
        logic        qual, trig, doPush, doFlush;
        logic [68:0] exp, ent;
        #1;
        if (OutReady && outValid0) begin
            checks++;
            pops0++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL pop0_unexpected got %h want no entry", {outPC0, outRd0, outData0});
            end else begin
                exp = q0.pop_front();
                if ({outPC0, outRd0, outData0} !== exp) begin
                    errors++;
                    $display("FAIL pop0_entry got %h want %h", {outPC0, outRd0, outData0}, exp);
                end
            end
        end
        if (OutReady && outValid1) begin
            checks++;
            pops1++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL pop1_unexpected got %h want no entry", {outPC1, outRd1, outData1});
            end else begin
                exp = q1.pop_front();
                if ({outPC1, outRd1, outData1} !== exp) begin
                    errors++;
                    $display("FAIL pop1_entry got %h want %h", {outPC1, outRd1, outData1}, exp);
                end
            end
        end
        qual    = WbValid && (WbRd != 5'd0);
        trig    = qual && (TrigAny || (WbPC == TriggerPC));
        doPush  = 1'b0;
        doFlush = 1'b0;
        ent     = {WbPC, WbRd, WbData};
        if (!Reset) begin
            q0.delete();
            q1.delete();
            mstate = IDLE;
        end else begin
            case (mstate)
                IDLE, DONE: if (Arm) begin mstate = ARMED; doFlush = 1'b1; end
                ARMED: begin
                    if (Stop) mstate = DONE;
                    else if (trig) begin mstate = CAPTURE; doPush = 1'b1; end
                end
                default: begin
                    if (Stop) mstate = DONE;
                    else doPush = qual;
                end
            endcase
            if (doFlush) begin
                q0.delete();
                q1.delete();
            end
            if (doPush) begin
                if (q0.size() < DEPTH) q0.push_back(ent);
                if (q1.size() == DEPTH) void'(q1.pop_front());
                q1.push_back(ent);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic ev(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
        WbValid = 1'b1; WbPC = pc; WbRd = rd; WbData = data;
        tick();
        WbValid = 1'b0; WbPC = '0; WbRd = '0; WbData = '0;
    endtask

    task automatic pulseArm();
        Arm = 1'b1; tick(); Arm = 1'b0;
    endtask

    task automatic pulseStop();
        Stop = 1'b1; tick(); Stop = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        checks++; if (state0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state0); end
        checks++; if (count0 !== 5'd0 || count1 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d/%0d want 0", count0, count1); end
        checks++; if (dropped0 !== 16'd0) begin errors++; $display("FAIL reset_dropped got %0d want 0", dropped0); end
        checks++; if (outValid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", outValid0); end
        checks++;
        if ({outPC0, outRd0, outData0} !== 69'd0) begin
            errors++; $display("FAIL reset_out got %h want 0", {outPC0, outRd0, outData0});
        end
    endtask

    task automatic test_trigger();
        TriggerPC = 32'h40; TrigAny = 1'b0;
        pulseArm();
        checks++; if (state0 !== 2'd1) begin errors++; $display("FAIL arm_state got %0d want 1", state0); end
        ev(32'h3C, 5'd5, 32'd1);
        checks++; if (state0 !== 2'd1 || count0 !== 5'd0) begin errors++; $display("FAIL pretrig got state %0d count %0d want 1/0", state0, count0); end
        ev(32'h40, 5'd8, 32'd5);
        checks++; if (state0 !== 2'd2 || count0 !== 5'd1) begin errors++; $display("FAIL trig got state %0d count %0d want 2/1", state0, count0); end
        checks++; if (outValid0 !== 1'b1 || outPC0 !== 32'h40) begin errors++; $display("FAIL trig_head got %b/%h want 1/40", outValid0, outPC0); end
        ev(32'h44, 5'd9, 32'd7);
        checks++; if (count0 !== 5'd2) begin errors++; $display("FAIL capture_count got %0d want 2", count0); end
    endtask

    task automatic test_drain();
        pops0 = 0;
        OutReady = 1'b1;
        tick(); tick();
        OutReady = 1'b0;
        checks++; if (pops0 !== 2) begin errors++; $display("FAIL drain_pops got %0d want 2", pops0); end
        checks++; if (outValid0 !== 1'b0 || count0 !== 5'd0) begin errors++; $display("FAIL drain_empty got %b/%0d want 0/0", outValid0, count0); end
        checks++;
        if ({outPC0, outRd0, outData0} !== 69'd0) begin
            errors++; $display("FAIL drain_out got %h want 0", {outPC0, outRd0, outData0});
        end
    endtask

    task automatic test_rd_zero();
        ev(32'h48, 5'd0, 32'd9);
        checks++; if (count0 !== 5'd0 || dropped0 !== 16'd0) begin errors++; $display("FAIL rd0 got count %0d dropped %0d want 0/0", count0, dropped0); end
        ev(32'h4C, 5'd3, 32'd1);
        checks++; if (count0 !== 5'd1) begin errors++; $display("FAIL rd3 got %0d want 1", count0); end
        OutReady = 1'b1; tick(); OutReady = 1'b0;
    endtask

    task automatic test_full_drop();
        pulseStop();
        TrigAny = 1'b1;
        pulseArm();
        for (int i = 1; i <= 18; i++) ev(32'h100 + 32'(4 * i), 5'((i % 31) + 1), 32'(i));
        checks++; if (count0 !== 5'd16 || dropped0 !== 16'd2) begin errors++; $display("FAIL full0 got count %0d dropped %0d want 16/2", count0, dropped0); end
        checks++; if (outData0 !== 32'd1) begin errors++; $display("FAIL full0_head got %0d want 1", outData0); end
        checks++; if (count1 !== 5'd16 || dropped1 !== 16'd2 || outData1 !== 32'd3) begin errors++; $display("FAIL full1 got %0d/%0d/%0d want 16/2/3", count1, dropped1, outData1); end
        OutReady = 1'b1;
        ev(32'h200, 5'd7, 32'd19);
        OutReady = 1'b0;
        checks++; if (count0 !== 5'd16 || dropped0 !== 16'd2) begin errors++; $display("FAIL fullpop0 got count %0d dropped %0d want 16/2", count0, dropped0); end
        checks++; if (outData0 !== 32'd2) begin errors++; $display("FAIL fullpop0_head got %0d want 2", outData0); end
        checks++; if (dropped1 !== 16'd2) begin errors++; $display("FAIL fullpop1_dropped got %0d want 2", dropped1); end
    endtask

    task automatic test_wrap();
        pulseStop();
        pulseArm();
        for (int i = 1; i <= 20; i++) ev(32'h300 + 32'(4 * i), 5'd12, 32'(i));
        checks++; if (count1 !== 5'd16 || dropped1 !== 16'd4) begin errors++; $display("FAIL wrap got count %0d dropped %0d want 16/4", count1, dropped1); end
        checks++; if (outData1 !== 32'd5) begin errors++; $display("FAIL wrap_head got %0d want 5", outData1); end
        checks++; if (outData0 !== 32'd1 || dropped0 !== 16'd4) begin errors++; $display("FAIL nowrap got head %0d dropped %0d want 1/4", outData0, dropped0); end
        pops1 = 0;
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        OutReady = 1'b0;
        checks++; if (pops1 !== 16 || count1 !== 5'd0) begin errors++; $display("FAIL wrap_drain got pops %0d count %0d want 16/0", pops1, count1); end
    endtask

    task automatic test_stop_priority();
        pulseStop();
        pulseArm();
        checks++; if (state0 !== 2'd1 || count0 !== 5'd0) begin errors++; $display("FAIL rearm got %0d/%0d want 1/0", state0, count0); end
        TrigAny = 1'b0; TriggerPC = 32'h40;
        Stop = 1'b1;
        ev(32'h40, 5'd4, 32'd4);
        Stop = 1'b0;
        checks++; if (state0 !== 2'd3 || count0 !== 5'd0) begin errors++; $display("FAIL stop_trig got %0d/%0d want 3/0", state0, count0); end
        Arm = 1'b1; Stop = 1'b1; tick();
        checks++; if (state0 !== 2'd1) begin errors++; $display("FAIL armstop_done got %0d want 1", state0); end
        tick();
        Arm = 1'b0; Stop = 1'b0;
        checks++; if (state0 !== 2'd3) begin errors++; $display("FAIL armstop_armed got %0d want 3", state0); end
    endtask

    task automatic test_mid_reset();
        TrigAny = 1'b1;
        pulseArm();
        for (int i = 0; i < 5; i++) ev(32'h500 + 32'(4 * i), 5'd2, 32'(100 + i));
        checks++; if (state0 !== 2'd2 || count0 !== 5'd5) begin errors++; $display("FAIL pre_reset got %0d/%0d want 2/5", state0, count0); end
        Reset = 1'b0; tick(); Reset = 1'b1;
        checks++; if (state0 !== 2'd0 || count0 !== 5'd0 || outValid0 !== 1'b0) begin errors++; $display("FAIL mid_reset got %0d/%0d/%b want 0/0/0", state0, count0, outValid0); end
        pulseArm();
        for (int i = 1; i <= 18; i++) ev(32'h600 + 32'(4 * i), 5'd6, 32'(i));
        OutReady = 1'b1;
        for (int i = 0; i < 13; i++) tick();
        OutReady = 1'b0;
        pulseStop();
        checks++; if (state0 !== 2'd3 || count0 !== 5'd3 || dropped0 !== 16'd2) begin errors++; $display("FAIL done got %0d/%0d/%0d want 3/3/2", state0, count0, dropped0); end
        pulseArm();
        checks++; if (state0 !== 2'd1 || count0 !== 5'd0 || dropped0 !== 16'd0) begin errors++; $display("FAIL arm_flush got %0d/%0d/%0d want 1/0/0", state0, count0, dropped0); end
    endtask

    task automatic test_back_to_back();
        pops0 = 0;
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) ev(32'h700 + 32'(4 * i), 5'(i + 1), 32'($urandom));
        checks++; if (count0 !== 5'd1 || count1 !== 5'd1) begin errors++; $display("FAIL b2b_count got %0d/%0d want 1/1", count0, count1); end
        tick();
        OutReady = 1'b0;
        checks++; if (pops0 !== 10 || count0 !== 5'd0) begin errors++; $display("FAIL b2b_pops got %0d count %0d want 10/0", pops0, count0); end
    endtask

    initial begin
        Reset = 1'b0; Arm = 1'b0; Stop = 1'b0; TrigAny = 1'b0; OutReady = 1'b0;
        TriggerPC = '0; WbValid = 1'b0; WbPC = '0; WbRd = '0; WbData = '0;
        test_reset();
        test_trigger();
        test_drain();
        test_rd_zero();
        test_full_drop();
        test_wrap();
        test_stop_priority();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
